// File: rtl/spi_pkg.sv
// Shared SPI slave types: FSM state encoding, read sub-phase encoding, RAM command codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    // Top-level frame FSM states
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Sub-phase inside READ_DATA: receive the frame, wait for the RAM byte,
    // shift it out on MISO, then sit quietly until SS_n rises
    typedef enum logic [1:0] {
        RD_RX,
        RD_WAIT,
        RD_SHIFT,
        RD_DONE
    } rd_phase_t;

    // RAM command codes carried in frame bits [9:8]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_W = 10;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises 10-bit MOSI frames to the RAM and serialises the RAM read byte on MISO.
// Latency: rx_valid one cycle after the 10th frame bit; MISO bit 7 one cycle after tx_valid capture.
// Backpressure: none; SS_n high aborts any frame or MISO transfer on the next edge.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   SS_n, MOSI, MISO  - SPI slave select, master data in, read data out
//   rx_data, rx_valid - received frame {cmd[1:0], payload} and its one-cycle qualifier
//   tx_data, tx_valid - RAM read byte and its qualifier (accepted only while awaiting read data)
module spi_slave
    import spi_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [ADDR_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FW = ADDR_W + 2;

    state_t            state;
    state_t            state_nxt;
    rd_phase_t         rd_phase;
    logic [3:0]        bit_cnt;
    logic [3:0]        miso_cnt;
    logic [FW-1:0]     rx_shift;
    logic [ADDR_W-1:0] tx_byte;
    logic              rd_addr_received;
    logic              in_frame;

    assign in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the CHK_CMD bit only steers the FSM and is never stored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!SS_n) state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)                  state_nxt = IDLE;
                else if (!MOSI)            state_nxt = WRITE;
                else if (rd_addr_received) state_nxt = READ_DATA;
                else                       state_nxt = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame shifter, read-address tracking and MISO serialiser.
    // bit_cnt stops at FW once a frame is complete, so trailing MOSI bits are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            MISO             <= 1'b0;
            bit_cnt          <= '0;
            miso_cnt         <= '0;
            rx_shift         <= '0;
            tx_byte          <= '0;
            rd_addr_received <= 1'b0;
            rd_phase         <= RD_RX;
        end else begin
            rx_valid <= 1'b0;
            if (!in_frame || SS_n) begin
                // Outside a frame, or aborting one: drop all progress, keep rd_addr_received
                bit_cnt  <= '0;
                miso_cnt <= '0;
                MISO     <= 1'b0;
                rd_phase <= RD_RX;
            end else if (bit_cnt < 4'(FW)) begin
                rx_shift <= {rx_shift[FW-2:0], MOSI};
                bit_cnt  <= bit_cnt + 4'd1;
                if (bit_cnt == 4'(FW - 1)) begin
                    rx_data  <= {rx_shift[FW-2:0], MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD) begin
                        rd_addr_received <= 1'b1;
                    end
                    if (state == READ_DATA) begin
                        rd_addr_received <= 1'b0;
                        rd_phase         <= RD_WAIT;
                    end
                end
            end else if (state == READ_DATA) begin
                case (rd_phase)
                    RD_WAIT: begin
                        if (tx_valid) begin
                            // Bit 7 goes out directly; the rest shift out of tx_byte
                            tx_byte  <= tx_data;
                            MISO     <= tx_data[ADDR_W-1];
                            miso_cnt <= 4'(ADDR_W - 1);
                            rd_phase <= RD_SHIFT;
                        end
                    end
                    RD_SHIFT: begin
                        if (miso_cnt != 4'd0) begin
                            MISO     <= tx_byte[ADDR_W-2];
                            tx_byte  <= {tx_byte[ADDR_W-2:0], 1'b0};
                            miso_cnt <= miso_cnt - 4'd1;
                        end else begin
                            MISO     <= 1'b0;
                            rd_phase <= RD_DONE;
                        end
                    end
                    default: MISO <= 1'b0;
                endcase
            end
        end
    end

endmodule
